// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes the RX line, samples each bit at its centre and
// delivers good bytes with a one-cycle strobe; a bad stop bit gives a one-cycle error strobe instead.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 104,
  localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       recv_error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_rx_s;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_byte;
  logic             r_received;
  logic             r_recv_error;

  logic w_half_done;
  logic w_bit_done;

  assign w_half_done = (r_cnt == HALF_M1);
  assign w_bit_done  = (r_cnt == FULL_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= 1'b1;
      r_rx_s       <= 1'b1;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_rx_byte    <= '0;
      r_received   <= 1'b0;
      r_recv_error <= 1'b0;
    end else begin
      r_sync1      <= rx;
      r_rx_s       <= r_sync1;
      r_received   <= 1'b0;
      r_recv_error <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) r_state <= START;
        end
        START: begin
          // A line that is high again at mid start bit was only a glitch.
          if (w_half_done) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= IDLE;
            end else begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_done) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_rx_s;
            if (r_bit_idx == 3'd7) r_state <= STOP;
            else r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving mid stop bit keeps back-to-back start edges catchable.
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_rx_byte  <= r_shift;
              r_received <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_recv_error <= 1'b1;
              r_state      <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BREAK: begin
          r_cnt <= '0;
          if (r_rx_s) r_state <= IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign received     = r_received;
  assign recv_error   = r_recv_error;
  assign rx_byte      = r_rx_byte;
  assign is_receiving = (r_state != IDLE);

endmodule
